// File: rtl/uart_fifo_core.sv
// Full-duplex UART with show-ahead TX/RX FIFOs, sticky overrun/framing flags.
// Optional parity (even, between data and stop) is enabled by UART_PARITY_EN.
module uart_fifo_core_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop frees the slot this same cycle, so a full FIFO still takes the push
  assign do_push = push && (!full || pop);
  assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

module uart_fifo_core #(
  parameter int clk_freq   = 50000000,
  parameter int baud_rate  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  output logic                 frame_err
`ifdef UART_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int DIV = clk_freq / baud_rate;
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_st, tx_st_nxt;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_sh, tx_head;
  logic                 tx_q_empty, tx_pop, tx_last, tx_bit, tx_busy_q;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_wr), .wdata(tx_data), .pop(tx_pop),
    .rdata(tx_head), .empty(tx_q_empty), .full(tx_full)
  );

  assign tx_last = (tx_st == STOP) ? (tx_cnt == STOP_LAST) : (tx_cnt == BIT_LAST);
  assign tx_busy = tx_busy_q || !tx_q_empty;

  always_ff @(posedge clk) begin
    if (reset) tx_st <= IDLE;
    else       tx_st <= tx_st_nxt;
  end

  always_comb begin
    tx_st_nxt = tx_st;
    case (tx_st)
      IDLE:   if (!tx_q_empty) tx_st_nxt = START;
      START:  if (tx_last) tx_st_nxt = DATA;
      DATA:   if (tx_last && tx_idx == DATA_LAST)
`ifdef UART_PARITY_EN
                tx_st_nxt = PARITY;
`else
                tx_st_nxt = STOP;
`endif
      PARITY: if (tx_last) tx_st_nxt = STOP;
      STOP:   if (tx_last) tx_st_nxt = tx_q_empty ? IDLE : START;
      default: tx_st_nxt = IDLE;
    endcase
  end

  // reloading straight from STOP keeps back-to-back frames gapless
  always_comb begin
    tx_pop = !tx_q_empty && (tx_st == IDLE || (tx_st == STOP && tx_last));
    case (tx_st)
      START:  tx_bit = 1'b0;
      DATA:   tx_bit = tx_sh[0];
`ifdef UART_PARITY_EN
      PARITY: tx_bit = tx_par;
`endif
      default: tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_sh     <= '0;
      tx_out    <= 1'b1;
      tx_busy_q <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_out    <= tx_bit;
      // busy is aligned with the registered line, so it covers the last stop cycle
      tx_busy_q <= (tx_st != IDLE) || (tx_st_nxt != IDLE);
      tx_cnt    <= (tx_st == IDLE || tx_last) ? '0 : tx_cnt + 1'b1;
      if (tx_st != DATA) tx_idx <= '0;
      else if (tx_last)  tx_idx <= tx_idx + 1'b1;
      if (tx_pop) begin
        tx_sh  <= tx_head;
`ifdef UART_PARITY_EN
        tx_par <= ^tx_head;
`endif
      end else if (tx_st == DATA && tx_last) begin
        tx_sh <= tx_sh >> 1;
      end
    end
  end

  // ---------------- receiver ----------------
  state_t               rx_st, rx_st_nxt;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_s1, rx_s2, rx_prev, rx_fall, rx_hit;
  logic                 rx_push, rx_drop, rx_q_full;

  uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_sh), .pop(rx_rd),
    .rdata(rx_data), .empty(rx_empty), .full(rx_q_full)
  );

  assign rx_fall = rx_prev && !rx_s2;
  // START waits half a bit to land mid-bit; later states step a whole bit
  assign rx_hit  = (rx_st == START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) rx_st <= IDLE;
    else       rx_st <= rx_st_nxt;
  end

  always_comb begin
    rx_st_nxt = rx_st;
    case (rx_st)
      IDLE:   if (rx_fall) rx_st_nxt = START;
      START:  if (rx_hit) rx_st_nxt = rx_s2 ? IDLE : DATA;
      DATA:   if (rx_hit && rx_idx == DATA_LAST)
`ifdef UART_PARITY_EN
                rx_st_nxt = PARITY;
`else
                rx_st_nxt = STOP;
`endif
      PARITY: if (rx_hit) rx_st_nxt = STOP;
      STOP:   if (rx_hit) rx_st_nxt = IDLE;
      default: rx_st_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_st == STOP) && rx_hit;
    rx_drop = rx_push && rx_q_full && !rx_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt  <= (rx_st == IDLE || rx_hit) ? '0 : rx_cnt + 1'b1;
      if (rx_st != DATA) rx_idx <= '0;
      else if (rx_hit)   rx_idx <= rx_idx + 1'b1;
      if (rx_st == DATA && rx_hit) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
      if (rx_drop)    rx_overrun <= 1'b1;
      else if (rx_rd) rx_overrun <= 1'b0;
      if (rx_push && !rx_s2) frame_err <= 1'b1;
      else if (rx_rd)        frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      if (rx_st == PARITY && rx_hit && (rx_s2 != ^rx_sh)) parity_err <= 1'b1;
      else if (rx_rd)                                     parity_err <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: TX waveform model, loopback, RX vector table,
// glitch/break, overrun and TX-full/reset corners. DIV reduced to 64.
module tb_uart_fifo_core;
  localparam int CLK_F = 6400;
  localparam int BAUD  = 100;
  localparam int DIV   = CLK_F / BAUD;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int FD    = 16;

  logic          clk = 1'b0, reset = 1'b1;
  logic [DB-1:0] tx_data = '0;
  logic          tx_wr = 1'b0;
  logic          tx_full, tx_busy, tx_out;
  logic          rx_drv = 1'b1, loop_en = 1'b0, rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_rd_man = 1'b0, rx_rd_auto = 1'b0, rx_rd;
  logic          rx_empty, rx_overrun, frame_err;
`ifdef UART_PARITY_EN
  logic          parity_err;
`endif

  assign rx_in = loop_en ? tx_out : rx_drv;
  assign rx_rd = rx_rd_man | rx_rd_auto;

  uart_fifo_core #(
    .clk_freq(CLK_F), .baud_rate(BAUD), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .tx_busy(tx_busy), .tx_out(tx_out), .rx_in(rx_in), .rx_data(rx_data), .rx_rd(rx_rd),
    .rx_empty(rx_empty), .rx_overrun(rx_overrun), .frame_err(frame_err)
`ifdef UART_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int            total = 0, bad = 0;
  logic          auto_pop = 1'b0;
  logic [DB-1:0] got[$], burst[$];

  typedef struct {
    logic [DB-1:0] d;
    logic          stop_hi;
    logic [DB-1:0] exp_d;
    logic          exp_fe;
  } rx_vec_t;
  rx_vec_t tbl[5];

  always @(negedge clk) begin
    rx_rd_auto = 1'b0;
    if (auto_pop && !rx_empty) begin
      got.push_back(rx_data);
      rx_rd_auto = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; tx_wr = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; auto_pop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_one;
    rx_rd_man = 1'b1;
    @(negedge clk);
    rx_rd_man = 1'b0;
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_hi);
    rx_drv = 1'b0; cycles(DIV);
    for (int i = 0; i < DB; i++) begin rx_drv = d[i]; cycles(DIV); end
    rx_drv = stop_hi; cycles(DIV);
    rx_drv = 1'b1; cycles(DIV);
  endtask

  // Writes 'burst' back to back and compares tx_out to the ideal frame train.
  task automatic run_loop;
    got.delete(); loop_en = 1'b1; auto_pop = 1'b1;
    fork
      begin
        for (int i = 0; i < burst.size(); i++) begin
          tx_wr = 1'b1; tx_data = burst[i]; @(negedge clk);
        end
        tx_wr = 1'b0;
      end
      begin
        int m;
        @(negedge clk); check("tx_busy_push", tx_busy, 1);
        @(negedge clk); check("tx_latency_idle", tx_out, 1);
        @(negedge clk);
        for (int i = 0; i < burst.size(); i++) begin
          logic [DB-1:0] w;
          w = burst[i]; m = 0;
          for (int b = 0; b < 1 + DB + SB; b++) begin
            logic e;
            e = (b == 0) ? 1'b0 : (b <= DB) ? w[b-1] : 1'b1;
            for (int c = 0; c < DIV; c++) begin
              if (tx_out === e) m++;
              if (i == burst.size() - 1 && b == DB + SB && c == DIV - 1)
                check("tx_busy_stop", tx_busy, 1);
              @(negedge clk);
            end
          end
          check("tx_frame", m, (1 + DB + SB) * DIV);
        end
        check("tx_busy_end", tx_busy, 0);
      end
    join
    cycles(4);
    auto_pop = 1'b0;
    check("rx_count", got.size(), burst.size());
    for (int i = 0; i < burst.size(); i++)
      if (i < got.size()) check("rx_word", got[i], burst[i]);
    check("lb_overrun", rx_overrun, 0);
    check("lb_frame_err", frame_err, 0);
  endtask

  initial begin
    logic [DB-1:0] q[$];
    logic          ovr, fe, sh;
    logic [DB-1:0] d;

    tbl[0] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 8'h81, 1'b1};

    @(negedge clk);
    do_reset;
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);

    burst.delete(); burst.push_back(8'hA5);
    run_loop;
    burst.delete(); burst.push_back(8'h55); burst.push_back(8'h00); burst.push_back(8'hFF);
    run_loop;
    for (int r = 0; r < 3; r++) begin
      burst.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) burst.push_back(DB'($urandom));
      run_loop;
    end

    loop_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_frame(tbl[i].d, tbl[i].stop_hi);
      check("vec_not_empty", rx_empty, 0);
      check("vec_rx_data", rx_data, tbl[i].exp_d);
      check("vec_frame_err", frame_err, tbl[i].exp_fe);
      pop_one;
      check("vec_empty_after", rx_empty, 1);
      check("vec_fe_cleared", frame_err, 0);
    end

    rx_drv = 1'b0; cycles(20); rx_drv = 1'b1; cycles(3 * DIV);
    check("glitch_empty", rx_empty, 1);
    check("glitch_fe", frame_err, 0);

    rx_drv = 1'b0; cycles(30 * DIV);
    check("break_frame", rx_empty, 0);
    check("break_data", rx_data, 0);
    check("break_fe", frame_err, 1);
    pop_one;
    cycles(10 * DIV);
    check("break_once", rx_empty, 1);
    rx_drv = 1'b1; cycles(DIV);

    // overrun with a random stop-bit mix against a queue model
    do_reset;
    q.delete(); ovr = 1'b0; fe = 1'b0;
    for (int i = 0; i < FD + 1; i++) begin
      d  = DB'($urandom);
      sh = ($urandom_range(0, 3) != 0);
      drive_frame(d, sh);
      if (!sh) fe = 1'b1;
      if (q.size() < FD) q.push_back(d);
      else ovr = 1'b1;
    end
    check("ovr_flag", rx_overrun, ovr);
    check("ovr_frame_err", frame_err, fe);
    for (int i = 0; i < q.size(); i++) begin
      check("ovr_word", rx_data, q[i]);
      pop_one;
      if (i == 0) begin
        check("ovr_cleared", rx_overrun, 0);
        check("ovr_fe_cleared", frame_err, 0);
      end
    end
    check("ovr_drained", rx_empty, 1);

    // TX FIFO full, ignored write, reset in the middle of DATA
    do_reset;
    loop_en = 1'b1;
    for (int i = 0; i < FD + 1; i++) begin
      tx_wr = 1'b1; tx_data = DB'(i); @(negedge clk);
    end
    tx_wr = 1'b0;
    check("tx_full_set", tx_full, 1);
    tx_wr = 1'b1; tx_data = 8'hEE; @(negedge clk);
    tx_wr = 1'b0;
    check("tx_full_hold", tx_full, 1);
    cycles(4 * DIV);
    check("tx_mid_data", tx_out, 0);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("abort_tx_out", tx_out, 1);
    check("abort_tx_full", tx_full, 0);
    check("abort_tx_busy", tx_busy, 0);
    check("abort_rx_empty", rx_empty, 1);
    cycles(12 * DIV);
    check("abort_quiet_rx", rx_empty, 1);
    check("abort_quiet_tx", tx_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
